// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared definitions for the data-memory load/store sequencer:
// RISC-V funct3 codes, FSM state encoding and request-legality helpers.
package dmem_lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_t;

  // Stores only exist as SB/SH/SW; loads additionally allow the unsigned variants.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 > F3_W);
    end
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return (off != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Request/response handshake and word-wide memory bus of the load/store sequencer.
// The master side is the core plus memory; the slave side is the sequencer itself.
interface dmem_lsu_ctrl_if #(parameter int XLEN = 32);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;

  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wr_data;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] mem_rd_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wr_data, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wr_data, mem_read, mem_write
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: little-endian byte/half extraction with sign or zero
// extension for loads, and byte/half lane replacement for read-modify-write stores.
module dmem_lane_align
  import dmem_lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] rd_word,
  input  logic [15:0]     store_lo,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rd_word[{byte_off, 3'b000} +: 8];
  assign sel_half = rd_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rd_word;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, sel_half};
      default: load_data = rd_word;
    endcase
  end

  // Only the addressed lane is overwritten; the rest of the fetched word is kept.
  always_comb begin
    merged_word = rd_word;
    case (funct3)
      F3_B:    merged_word[{byte_off, 3'b000} +: 8] = store_lo[7:0];
      F3_H:    merged_word[{byte_off[1], 4'b0000} +: 16] = store_lo;
      default: merged_word = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide data memory.
// One request in flight; sub-word stores are done as read-modify-write pairs.
module dmem_lsu_ctrl
  import dmem_lsu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
) (
  input logic            clk,
  input logic            rst,
  dmem_lsu_ctrl_if.slave bus
);

  lsu_state_t      state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [15:0]     wdata_q;

  logic [XLEN-1:0] word_idx;
  logic            accept_fault;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  assign word_idx     = {2'b00, bus.req_addr[XLEN-1:2]};
  assign accept_fault = funct3_illegal(bus.req_we, bus.req_funct3)
                     || access_misaligned(bus.req_funct3, bus.req_addr[1:0])
                     || (word_idx >= XLEN'(DEPTH));

  dmem_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .funct3     (f3_q),
    .byte_off   (off_q),
    .rd_word    (bus.mem_rd_data),
    .store_lo   (wdata_q),
    .load_data  (load_data),
    .merged_word(merged_word)
  );

  // All bus outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      we_q            <= 1'b0;
      f3_q            <= 3'd0;
      off_q           <= 2'd0;
      wdata_q         <= 16'd0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_fault  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q           <= bus.req_we;
            f3_q           <= bus.req_funct3;
            off_q          <= bus.req_addr[1:0];
            wdata_q        <= bus.req_wdata[15:0];
            bus.req_ready  <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_addr   <= word_idx;
            if (accept_fault) begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_fault <= 1'b1;
            end else if (!bus.req_we) begin
              state        <= ST_ACCESS;
              bus.mem_read <= 1'b1;
            end else if (bus.req_funct3 == F3_W) begin
              state           <= ST_ACCESS;
              bus.mem_write   <= 1'b1;
              bus.mem_wr_data <= bus.req_wdata;
            end else begin
              state        <= ST_RMW_RD;
              bus.mem_read <= 1'b1;
            end
          end
        end

        ST_ACCESS: begin
          bus.mem_read   <= 1'b0;
          bus.mem_write  <= 1'b0;
          bus.resp_valid <= 1'b1;
          if (!we_q) begin
            bus.resp_rdata <= load_data;
          end
          state <= ST_RESP;
        end

        // The merge is taken straight from the word being read this cycle.
        ST_RMW_RD: begin
          bus.mem_read    <= 1'b0;
          bus.mem_write   <= 1'b1;
          bus.mem_wr_data <= merged_word;
          state           <= ST_RMW_WR;
        end

        ST_RMW_WR: begin
          bus.mem_write  <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= ST_RESP;
        end

        ST_RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_fault <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
          state          <= ST_IDLE;
        end

        default: begin
          bus.mem_read   <= 1'b0;
          bus.mem_write  <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
